mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the core's single external memory port between instruction fetch (IF, read-only) and the load/store path (MEM, read/write).
- Sits between the IF/MEM pipeline stages and the bus interface.
- Accepts one request at a time, drives a valid/ready bus request, and routes the response back to the owning requester.
- MEM has priority; a burst counter prevents IF starvation.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width (mask width is DATA_W/8)
- MEM_BURST_MAX, 4, max consecutive MEM grants while IF is pending
- TIMEOUT_CYCLES, 255, WAIT-state watchdog limit (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req_valid  in  1  IF read request
- if_req_addr  in  ADDR_W  IF address
- if_req_ready  out  1  IF request accepted this cycle
- if_resp_valid  out  1  IF response, one-cycle pulse
- if_resp_data  out  DATA_W  IF read data
- if_resp_err  out  1  IF response error
- mem_req_valid  in  1  MEM request
- mem_req_wen  in  1  1 = write, 0 = read
- mem_req_addr  in  ADDR_W  MEM address
- mem_req_wdata  in  DATA_W  write data
- mem_req_wmask  in  DATA_W/8  byte strobes
- mem_req_ready  out  1  MEM request accepted this cycle
- mem_resp_valid  out  1  MEM response, one-cycle pulse
- mem_resp_data  out  DATA_W  MEM read data
- mem_resp_err  out  1  MEM response error
- bus_req_valid  out  1  bus request valid
- bus_req_ready  in  1  bus accepts request
- bus_req_wen  out  1  bus write enable
- bus_req_addr  out  ADDR_W  bus address
- bus_req_wdata  out  DATA_W  bus write data
- bus_req_wmask  out  DATA_W/8  bus byte strobes
- bus_resp_valid  in  1  bus response valid
- bus_resp_data  in  DATA_W  bus response data

Behaviour:
- Clocking/reset: single clock clk; reset rst is synchronous, active-high.
- States: IDLE, REQ, WAIT. Registers: owner (0 = IF, 1 = MEM), latched request fields, burst counter bcnt.
- Reset:
  - State IDLE, owner 0, bcnt 0.
  - All outputs 0, including latched bus fields and resp data.
  - Reset mid-transaction abandons it silently; no response is issued.
- IDLE, grant decision (combinational req_ready, at most one high):
  - MEM wins if mem_req_valid and not (if_req_valid and bcnt == MEM_BURST_MAX).
  - Otherwise IF wins if if_req_valid.
  - The winner's req_ready = 1; its fields are latched at the edge; next state REQ.
  - IF requests latch wen=0, wdata=0, wmask=0.
  - req_ready is 0 in REQ and WAIT.
- bcnt rules:
  - MEM grant with if_req_valid high: bcnt+1, saturating at MEM_BURST_MAX.
  - Any IF grant: bcnt cleared.
  - MEM grant with if_req_valid low: bcnt cleared.
- REQ:
  - bus_req_valid = 1; bus fields driven from the latched registers and held stable until accepted.
  - When bus_req_ready is high: next state WAIT; bus_req_valid drops the following cycle.
- WAIT:
  - On bus_resp_valid: at that edge, the owner's resp_valid <= 1 and resp_data <= bus_resp_data (0 for writes); resp_err <= 0; next state IDLE.
  - Response latency is one cycle after bus_resp_valid.
  - resp_valid is a one-cycle pulse. resp_data holds until the next response.
  - A new request may be accepted in the same cycle resp_valid is high.
- bus_resp_valid seen in IDLE or REQ is ignored.
- The non-owner's resp_valid stays 0.
- Minimum transaction: grant edge → REQ (ready same cycle) → WAIT → response edge → resp_valid pulse, i.e. 3 cycles after grant.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without bus_resp_valid.
  - When it reaches TIMEOUT_CYCLES: the owner gets resp_valid = 1, resp_err = 1, resp_data = 0; state goes to IDLE.
  - A bus response arriving in the same cycle as the timeout wins (normal response, err = 0).
- ARB_TIMEOUT_EN undefined:
  - No counter; WAIT waits indefinitely.
  - if_resp_err and mem_resp_err are constant 0.

Test Plan:
- IF read: if_req_valid with addr 0x80000000; bus_req_ready = 1; bus_resp_valid 3 cycles later with data 0x00000013 → bus_req_addr = 0x80000000, bus_req_wen = 0; if_resp_valid pulses 1 cycle after bus_resp_valid, data 0x13; mem_resp_valid stays 0.
- Simultaneous: if_req_valid and mem_req_valid both high in IDLE → mem_req_ready = 1, if_req_ready = 0; MEM completes, then IF granted in the next IDLE cycle.
- MEM write: wen = 1, addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F; bus_req_ready low for 4 cycles → bus fields stable all 4 cycles; mem_resp_valid follows bus_resp_valid with mem_resp_data = 0.
- Starvation: MEM_BURST_MAX = 2; mem_req_valid held high and if_req_valid high → grant order MEM, MEM, IF, MEM.
- Reset in WAIT: rst pulsed during WAIT, then bus_resp_valid asserted → no resp_valid on either side; state IDLE; all outputs 0.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8): MEM read with no bus response → after 8 WAIT cycles mem_resp_valid = 1, mem_resp_err = 1, data 0; next request accepted normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the IF/MEM request ports, the arbiter and the external bus.
// The slave modport is the arbiter's view; master is the surrounding pipeline/bus view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic                  if_req_valid;
  logic [ADDR_W-1:0]     if_req_addr;
  logic                  if_req_ready;
  logic                  if_resp_valid;
  logic [DATA_W-1:0]     if_resp_data;
  logic                  if_resp_err;

  logic                  mem_req_valid;
  logic                  mem_req_wen;
  logic [ADDR_W-1:0]     mem_req_addr;
  logic [DATA_W-1:0]     mem_req_wdata;
  logic [DATA_W/8-1:0]   mem_req_wmask;
  logic                  mem_req_ready;
  logic                  mem_resp_valid;
  logic [DATA_W-1:0]     mem_resp_data;
  logic                  mem_resp_err;

  logic                  bus_req_valid;
  logic                  bus_req_ready;
  logic                  bus_req_wen;
  logic [ADDR_W-1:0]     bus_req_addr;
  logic [DATA_W-1:0]     bus_req_wdata;
  logic [DATA_W/8-1:0]   bus_req_wmask;
  logic                  bus_resp_valid;
  logic [DATA_W-1:0]     bus_resp_data;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
    input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
    output bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wmask,
    input  bus_req_ready, bus_resp_valid, bus_resp_data
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
    output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
    input  bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wmask,
    output bus_req_ready, bus_resp_valid, bus_resp_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; MEM has priority, bounded
// by a burst counter. Define ARB_TIMEOUT_EN to add a WAIT-state response watchdog.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 64,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned MEM_BURST_MAX  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave arb_if
);

  localparam int unsigned      MaskW   = DATA_W / 8;
  localparam int unsigned      BcntW   = $clog2(MEM_BURST_MAX + 1);
  localparam logic [BcntW-1:0] BcntMax = BcntW'(MEM_BURST_MAX);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;  // 0 = IF, 1 = MEM
  logic [BcntW-1:0]    bcnt_q, bcnt_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MaskW-1:0]    wmask_q, wmask_d;

  logic                if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                if_rerr_q, if_rerr_d;
  logic                mem_rvalid_q, mem_rvalid_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                mem_rerr_q, mem_rerr_d;

  logic                grant_if, grant_mem;
  logic                rsp_fire, rsp_err;
  logic [DATA_W-1:0]   rsp_data;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned      TcntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TcntW-1:0] TcntLast = TcntW'(TIMEOUT_CYCLES - 1);
  logic [TcntW-1:0] tcnt_q, tcnt_d;
`endif

  // MEM yields only once it has used its burst allowance while IF is waiting.
  always_comb begin
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    if (state_q == StIdle) begin
      grant_mem = arb_if.mem_req_valid && !(arb_if.if_req_valid && (bcnt_q == BcntMax));
      grant_if  = !grant_mem && arb_if.if_req_valid;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    bcnt_d       = bcnt_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    if_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    if_rerr_d    = if_rerr_q;
    mem_rvalid_d = 1'b0;
    mem_rdata_d  = mem_rdata_q;
    mem_rerr_d   = mem_rerr_q;
    rsp_fire     = 1'b0;
    rsp_err      = 1'b0;
    rsp_data     = '0;
`ifdef ARB_TIMEOUT_EN
    tcnt_d       = tcnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (grant_mem) begin
          state_d = StReq;
          owner_d = 1'b1;
          wen_d   = arb_if.mem_req_wen;
          addr_d  = arb_if.mem_req_addr;
          wdata_d = arb_if.mem_req_wdata;
          wmask_d = arb_if.mem_req_wmask;
          if (!arb_if.if_req_valid) begin
            bcnt_d = '0;
          end else if (bcnt_q != BcntMax) begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end else if (grant_if) begin
          state_d = StReq;
          owner_d = 1'b0;
          wen_d   = 1'b0;
          addr_d  = arb_if.if_req_addr;
          wdata_d = '0;
          wmask_d = '0;
          bcnt_d  = '0;
        end
      end
      StReq: begin
        if (arb_if.bus_req_ready) begin
          state_d = StWait;
`ifdef ARB_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
      end
      StWait: begin
        if (arb_if.bus_resp_valid) begin
          state_d  = StIdle;
          rsp_fire = 1'b1;
          rsp_data = wen_q ? '0 : arb_if.bus_resp_data;
`ifdef ARB_TIMEOUT_EN
        end else if (tcnt_q == TcntLast) begin
          state_d  = StIdle;
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    if (rsp_fire) begin
      if (owner_q) begin
        mem_rvalid_d = 1'b1;
        mem_rdata_d  = rsp_data;
        mem_rerr_d   = rsp_err;
      end else begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = rsp_data;
        if_rerr_d   = rsp_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      bcnt_q       <= '0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      if_rerr_q    <= 1'b0;
      mem_rvalid_q <= 1'b0;
      mem_rdata_q  <= '0;
      mem_rerr_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tcnt_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      bcnt_q       <= bcnt_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      if_rerr_q    <= if_rerr_d;
      mem_rvalid_q <= mem_rvalid_d;
      mem_rdata_q  <= mem_rdata_d;
      mem_rerr_q   <= mem_rerr_d;
`ifdef ARB_TIMEOUT_EN
      tcnt_q       <= tcnt_d;
`endif
    end
  end

  assign arb_if.if_req_ready   = grant_if;
  assign arb_if.mem_req_ready  = grant_mem;
  assign arb_if.if_resp_valid  = if_rvalid_q;
  assign arb_if.if_resp_data   = if_rdata_q;
  assign arb_if.if_resp_err    = if_rerr_q;
  assign arb_if.mem_resp_valid = mem_rvalid_q;
  assign arb_if.mem_resp_data  = mem_rdata_q;
  assign arb_if.mem_resp_err   = mem_rerr_q;
  assign arb_if.bus_req_valid  = (state_q == StReq);
  assign arb_if.bus_req_wen    = wen_q;
  assign arb_if.bus_req_addr   = addr_q;
  assign arb_if.bus_req_wdata  = wdata_q;
  assign arb_if.bus_req_wmask  = wmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (burst limit 2, timeout 8).
module tb_mem_port_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  mem_port_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .MEM_BURST_MAX  (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .arb_if (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Called in a REQ cycle with bus_req_ready high; returns in the IDLE cycle carrying the pulse.
  task automatic finish_txn(input logic [63:0] d);
    tick();
    bus_if.bus_resp_valid = 1'b1;
    bus_if.bus_resp_data  = d;
    tick();
    bus_if.bus_resp_valid = 1'b0;
    bus_if.bus_resp_data  = '0;
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_order [4];
    exp_order = '{2'b01, 2'b01, 2'b10, 2'b01};  // {if_ready, mem_ready}

    rst                  = 1'b1;
    bus_if.if_req_valid  = 1'b0;
    bus_if.if_req_addr   = '0;
    bus_if.mem_req_valid = 1'b0;
    bus_if.mem_req_wen   = 1'b0;
    bus_if.mem_req_addr  = '0;
    bus_if.mem_req_wdata = '0;
    bus_if.mem_req_wmask = '0;
    bus_if.bus_req_ready = 1'b0;
    bus_if.bus_resp_valid = 1'b0;
    bus_if.bus_resp_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    settle();

    // Reset state
    check_eq("rst_bus_valid", 64'(bus_if.bus_req_valid), 64'd0);
    check_eq("rst_bus_addr", bus_if.bus_req_addr, 64'd0);
    check_eq("rst_if_ready", 64'(bus_if.if_req_ready), 64'd0);
    check_eq("rst_mem_ready", 64'(bus_if.mem_req_ready), 64'd0);
    check_eq("rst_if_rvalid", 64'(bus_if.if_resp_valid), 64'd0);
    check_eq("rst_mem_rdata", bus_if.mem_resp_data, 64'd0);

    // IF read
    bus_if.if_req_valid  = 1'b1;
    bus_if.if_req_addr   = 64'h8000_0000;
    bus_if.bus_req_ready = 1'b1;
    settle();
    check_eq("if_grant_ready", 64'(bus_if.if_req_ready), 64'd1);
    check_eq("if_grant_memready", 64'(bus_if.mem_req_ready), 64'd0);
    tick();
    bus_if.if_req_valid = 1'b0;
    settle();
    check_eq("if_req_busvalid", 64'(bus_if.bus_req_valid), 64'd1);
    check_eq("if_req_busaddr", bus_if.bus_req_addr, 64'h8000_0000);
    check_eq("if_req_buswen", 64'(bus_if.bus_req_wen), 64'd0);
    check_eq("if_req_readylow", 64'(bus_if.if_req_ready), 64'd0);
    tick();
    settle();
    check_eq("if_wait_busvalid", 64'(bus_if.bus_req_valid), 64'd0);
    tick();
    bus_if.bus_resp_valid = 1'b1;
    bus_if.bus_resp_data  = 64'h13;
    settle();
    check_eq("if_rvalid_early", 64'(bus_if.if_resp_valid), 64'd0);
    tick();
    bus_if.bus_resp_valid = 1'b0;
    settle();
    check_eq("if_rvalid", 64'(bus_if.if_resp_valid), 64'd1);
    check_eq("if_rdata", bus_if.if_resp_data, 64'h13);
    check_eq("if_rerr", 64'(bus_if.if_resp_err), 64'd0);
    check_eq("if_mem_rvalid", 64'(bus_if.mem_resp_valid), 64'd0);
    tick();
    settle();
    check_eq("if_rvalid_pulse", 64'(bus_if.if_resp_valid), 64'd0);
    check_eq("if_rdata_hold", bus_if.if_resp_data, 64'h13);

    // Simultaneous IF + MEM: MEM first, IF granted in the response cycle
    bus_if.if_req_valid  = 1'b1;
    bus_if.mem_req_valid = 1'b1;
    bus_if.mem_req_addr  = 64'h1000;
    settle();
    check_eq("sim_mem_ready", 64'(bus_if.mem_req_ready), 64'd1);
    check_eq("sim_if_ready", 64'(bus_if.if_req_ready), 64'd0);
    tick();
    bus_if.mem_req_valid = 1'b0;
    settle();
    check_eq("sim_mem_busaddr", bus_if.bus_req_addr, 64'h1000);
    finish_txn(64'hAA);
    check_eq("sim_mem_rvalid", 64'(bus_if.mem_resp_valid), 64'd1);
    check_eq("sim_mem_rdata", bus_if.mem_resp_data, 64'hAA);
    check_eq("sim_if_rvalid", 64'(bus_if.if_resp_valid), 64'd0);
    check_eq("sim_if_ready2", 64'(bus_if.if_req_ready), 64'd1);
    tick();
    bus_if.if_req_valid = 1'b0;
    settle();
    check_eq("sim_if_busaddr", bus_if.bus_req_addr, 64'h8000_0000);
    finish_txn(64'h55);
    check_eq("sim_if_rdata", bus_if.if_resp_data, 64'h55);

    // MEM write, bus stalls 4 cycles; a stray bus response in REQ is ignored
    bus_if.bus_req_ready = 1'b0;
    bus_if.mem_req_valid = 1'b1;
    bus_if.mem_req_wen   = 1'b1;
    bus_if.mem_req_addr  = 64'h8000_1000;
    bus_if.mem_req_wdata = 64'hDEAD_BEEF;
    bus_if.mem_req_wmask = 8'h0F;
    settle();
    check_eq("wr_mem_ready", 64'(bus_if.mem_req_ready), 64'd1);
    tick();
    bus_if.mem_req_valid = 1'b0;
    bus_if.mem_req_wen   = 1'b0;
    bus_if.mem_req_addr  = 64'h1234;
    bus_if.mem_req_wdata = 64'h5678;
    bus_if.mem_req_wmask = 8'hF0;
    for (int i = 0; i < 4; i++) begin
      bus_if.bus_resp_valid = (i == 1);
      bus_if.bus_resp_data  = 64'h77;
      settle();
      check_eq($sformatf("wr_busvalid[%0d]", i), 64'(bus_if.bus_req_valid), 64'd1);
      check_eq($sformatf("wr_busaddr[%0d]", i), bus_if.bus_req_addr, 64'h8000_1000);
      check_eq($sformatf("wr_buswdata[%0d]", i), bus_if.bus_req_wdata, 64'hDEAD_BEEF);
      check_eq($sformatf("wr_buswmask[%0d]", i), 64'(bus_if.bus_req_wmask), 64'h0F);
      check_eq($sformatf("wr_buswen[%0d]", i), 64'(bus_if.bus_req_wen), 64'd1);
      check_eq($sformatf("wr_no_rvalid[%0d]", i), 64'(bus_if.mem_resp_valid), 64'd0);
      tick();
    end
    bus_if.bus_resp_valid = 1'b0;
    bus_if.bus_req_ready  = 1'b1;
    settle();
    check_eq("wr_busvalid_last", 64'(bus_if.bus_req_valid), 64'd1);
    finish_txn(64'h1234);
    check_eq("wr_mem_rvalid", 64'(bus_if.mem_resp_valid), 64'd1);
    check_eq("wr_mem_rdata", bus_if.mem_resp_data, 64'd0);

    // Starvation guard with burst limit 2
    bus_if.mem_req_valid = 1'b1;
    bus_if.mem_req_wen   = 1'b0;
    bus_if.mem_req_addr  = 64'h8000_2000;
    bus_if.if_req_valid  = 1'b1;
    bus_if.if_req_addr   = 64'h8000_0040;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq($sformatf("grant_order[%0d]", i),
               {62'b0, bus_if.if_req_ready, bus_if.mem_req_ready}, {62'b0, exp_order[i]});
      tick();
      finish_txn(64'h100 + 64'(i));
    end
    bus_if.mem_req_valid = 1'b0;
    bus_if.if_req_valid  = 1'b0;
    settle();
    check_eq("starve_mem_rdata", bus_if.mem_resp_data, 64'h103);
    check_eq("starve_if_rdata", bus_if.if_resp_data, 64'h102);

    // Reset during WAIT abandons the transaction
    bus_if.mem_req_valid = 1'b1;
    bus_if.mem_req_wen   = 1'b1;
    bus_if.mem_req_addr  = 64'h8000_3000;
    bus_if.mem_req_wdata = 64'hCAFE;
    bus_if.mem_req_wmask = 8'hFF;
    tick();
    bus_if.mem_req_valid = 1'b0;
    tick();
    settle();
    check_eq("rw_in_wait", 64'(bus_if.bus_req_valid), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_if.bus_resp_valid = 1'b1;
    bus_if.bus_resp_data  = 64'h77;
    settle();
    check_eq("rw_bus_addr", bus_if.bus_req_addr, 64'd0);
    check_eq("rw_bus_wdata", bus_if.bus_req_wdata, 64'd0);
    check_eq("rw_bus_wmask", 64'(bus_if.bus_req_wmask), 64'd0);
    check_eq("rw_bus_wen", 64'(bus_if.bus_req_wen), 64'd0);
    check_eq("rw_mem_rdata", bus_if.mem_resp_data, 64'd0);
    check_eq("rw_if_rdata", bus_if.if_resp_data, 64'd0);
    tick();
    bus_if.bus_resp_valid = 1'b0;
    settle();
    check_eq("rw_mem_rvalid", 64'(bus_if.mem_resp_valid), 64'd0);
    check_eq("rw_if_rvalid", 64'(bus_if.if_resp_valid), 64'd0);
    check_eq("rw_bus_valid", 64'(bus_if.bus_req_valid), 64'd0);

    // Normal MEM read after reset
    bus_if.mem_req_valid = 1'b1;
    bus_if.mem_req_wen   = 1'b0;
    bus_if.mem_req_addr  = 64'h10;
    settle();
    check_eq("post_mem_ready", 64'(bus_if.mem_req_ready), 64'd1);
    tick();
    bus_if.mem_req_valid = 1'b0;
    finish_txn(64'h99);
    check_eq("post_mem_rvalid", 64'(bus_if.mem_resp_valid), 64'd1);
    check_eq("post_mem_rdata", bus_if.mem_resp_data, 64'h99);
    check_eq("post_mem_rerr", 64'(bus_if.mem_resp_err), 64'd0);

`ifdef ARB_TIMEOUT_EN
    // Timeout: 8 silent WAIT cycles produce an error response
    bus_if.mem_req_valid = 1'b1;
    bus_if.mem_req_addr  = 64'h20;
    settle();
    tick();
    bus_if.mem_req_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      settle();
      check_eq($sformatf("to_no_rvalid[%0d]", i), 64'(bus_if.mem_resp_valid), 64'd0);
      tick();
    end
    settle();
    check_eq("to_rvalid", 64'(bus_if.mem_resp_valid), 64'd1);
    check_eq("to_rerr", 64'(bus_if.mem_resp_err), 64'd1);
    check_eq("to_rdata", bus_if.mem_resp_data, 64'd0);
    bus_if.mem_req_valid = 1'b1;
    settle();
    check_eq("to_next_ready", 64'(bus_if.mem_req_ready), 64'd1);
    tick();
    bus_if.mem_req_valid = 1'b0;
    finish_txn(64'h42);
    check_eq("to_next_rdata", bus_if.mem_resp_data, 64'h42);
    check_eq("to_next_rerr", 64'(bus_if.mem_resp_err), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
